// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
// Shared types and helpers for the FIFO write-port arbiter.
//   arb_state_t : ownership FSM states (used only when ARB_BURST_EN is defined)
//   PTR_RST     : reset value of the round-robin priority pointer
//   wrap_inc    : index increment with explicit wrap at num-1, so that
//                 non-power-of-two producer counts wrap correctly
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int unsigned PTR_RST = 0;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned num);
        return (idx == num - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin picker. Searches req starting at ptr, then
// ptr+1 ... NUM_REQ-1, 0 ... ptr-1, and returns the first requester.
// Ports:
//   req   in  NUM_REQ          request vector
//   ptr   in  $clog2(NUM_REQ)  index searched first
//   gnt   out NUM_REQ          one-hot pick, zero when nothing requests
//   idx   out $clog2(NUM_REQ)  index of the pick (0 when none)
//   found out 1                a pick was made
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       found
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] cand;

    // NOTE: combinational logic uses blocking assignments and gives every
    // output a default first, so no path leaves a value unassigned (no latch).
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[cand]) begin
                found     = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
            cand = IDX_W'(wrap_inc(32'(cand), NUM_REQ));
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter sharing the FIFO write port between NUM_REQ producers.
// At most one producer is accepted per cycle; the grant is combinational
// and the FIFO captures the granted word on the same edge.
// Optional feature: define ARB_BURST_EN to let a producer hold the port for
// up to BURST_LEN consecutive beats (IDLE/BURST FSM plus beat counter).
// Ports:
//   clk           in  1                   clock, rising edge
//   reset         in  1                   synchronous, active-high
//   req           in  NUM_REQ             producer i has a word
//   req_data      in  NUM_REQ*DATA_WIDTH  producer i's word at [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt           out NUM_REQ             one-hot or zero; word written this edge
//   fifo_wr_ready in  1                   FIFO can accept a word
//   fifo_wr_en    out 1                   FIFO write enable
//   fifo_wr_data  out DATA_WIDTH          granted word, 0 when no grant
//   owner         out $clog2(NUM_REQ)     last-granted producer / burst owner
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 4,
    parameter int BURST_LEN  = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              gnt,
    input  logic                            fifo_wr_ready,
    output logic                            fifo_wr_en,
    output logic [DATA_WIDTH-1:0]           fifo_wr_data,
    output logic [$clog2(NUM_REQ)-1:0]      owner
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || BURST_LEN < 1) begin : g_param_check
        $error("fifo_wr_arbiter: NUM_REQ must be >= 2 and BURST_LEN >= 1");
    end

    logic [IDX_W-1:0]   ptr;
    logic [NUM_REQ-1:0] pick_req;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;
    logic               grant_ok;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (pick_req),
        .ptr   (ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Reset and backpressure both suppress the grant in the same cycle.
    assign grant_ok   = !reset && fifo_wr_ready;
    assign gnt        = grant_ok ? pick_gnt : '0;
    assign fifo_wr_en = |gnt;

    // gnt is one-hot or zero, so OR-ing the selected slices is the mux.
    always_comb begin
        fifo_wr_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                fifo_wr_data = fifo_wr_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef ARB_BURST_EN

    localparam int CNT_W = $clog2(BURST_LEN + 1);

    arb_state_t       state;
    logic [CNT_W-1:0] count;

    // While bursting only the owner may win; masking its req lets the same
    // picker serve both modes.
    always_comb begin
        pick_req = req;
        if (state == BURST) begin
            pick_req        = '0;
            pick_req[owner] = req[owner];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr   <= IDX_W'(PTR_RST);
            owner <= IDX_W'(PTR_RST);
            state <= IDLE;
            count <= '0;
        end else if (fifo_wr_ready) begin
            if (state == BURST) begin
                // Either the burst continues or the owner dropped req; in both
                // cases the next search starts just after the owner.
                ptr <= IDX_W'(wrap_inc(32'(owner), NUM_REQ));
                if (!req[owner]) begin
                    state <= IDLE;
                end else begin
                    count <= count + 1'b1;
                    if (count == CNT_W'(BURST_LEN - 1)) begin
                        state <= IDLE;
                    end
                end
            end else if (pick_found) begin
                ptr   <= IDX_W'(wrap_inc(32'(pick_idx), NUM_REQ));
                owner <= pick_idx;
                count <= CNT_W'(1);
                state <= (BURST_LEN > 1) ? BURST : IDLE;
            end
        end
    end

`else

    assign pick_req = req;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr   <= IDX_W'(PTR_RST);
            owner <= IDX_W'(PTR_RST);
        end else if (fifo_wr_ready && pick_found) begin
            ptr   <= IDX_W'(wrap_inc(32'(pick_idx), NUM_REQ));
            owner <= pick_idx;
        end
    end

`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
// Scoreboard bench for fifo_wr_arbiter. Two instances share the stimulus:
// dut_a with NUM_REQ=4 and dut_b with NUM_REQ=3 (non-power-of-two wrap).
// The driver computes the expected outputs from a round-robin reference
// model and queues them; the monitor pops and compares each cycle.
// Honours ARB_BURST_EN for both the DUTs and the model.
module tb_fifo_wr_arbiter;

    localparam int DW = 4;
    localparam int BL = 4;
`ifdef ARB_BURST_EN
    localparam bit BURST_MODE = 1'b1;
`else
    localparam bit BURST_MODE = 1'b0;
`endif

    typedef struct {
        logic [3:0] gnt;
        logic       en;
        logic [3:0] data;
        int         owner;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] req_data;
    logic        ready;

    logic [3:0]  gnt_a;
    logic        en_a;
    logic [3:0]  data_a;
    logic [1:0]  owner_a;
    logic [2:0]  gnt_b;
    logic        en_b;
    logic [3:0]  data_b;
    logic [1:0]  owner_b;

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut_a (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .req_data      (req_data),
        .gnt           (gnt_a),
        .fifo_wr_ready (ready),
        .fifo_wr_en    (en_a),
        .fifo_wr_data  (data_a),
        .owner         (owner_a)
    );

    fifo_wr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut_b (
        .clk           (clk),
        .reset         (reset),
        .req           (req[2:0]),
        .req_data      (req_data[11:0]),
        .gnt           (gnt_b),
        .fifo_wr_ready (ready),
        .fifo_wr_en    (en_b),
        .fifo_wr_data  (data_b),
        .owner         (owner_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    // Reference model state: value after the most recent edge.
    int m_ptr   [2] = '{0, 0};
    int m_owner [2] = '{0, 0};
    int m_beats [2] = '{0, 0};
    bit m_burst [2] = '{1'b0, 1'b0};

    task automatic check(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, u, act, exp, $time);
        end
    endtask

    // Expected outputs for this cycle's inputs, then advance the model
    // across the coming edge.
    task automatic model_step(input int u, input logic [3:0] r, input logic [15:0] d,
                              input bit rst, input bit rdy, output exp_t e);
        int n;
        int g;
        n = (u == 0) ? 4 : 3;
        g = -1;
        e.gnt   = '0;
        e.en    = 1'b0;
        e.data  = '0;
        e.owner = m_owner[u];
        if (!rst && rdy) begin
            if (m_burst[u]) begin
                if (r[m_owner[u]]) g = m_owner[u];
            end else begin
                for (int k = 0; k < n; k++) begin
                    if (g < 0 && r[(m_ptr[u] + k) % n]) g = (m_ptr[u] + k) % n;
                end
            end
        end
        if (g >= 0) begin
            e.gnt[g] = 1'b1;
            e.en     = 1'b1;
            e.data   = d[g*DW +: DW];
        end
        if (rst) begin
            m_ptr[u]   = 0;
            m_owner[u] = 0;
            m_beats[u] = 0;
            m_burst[u] = 1'b0;
        end else if (rdy) begin
            if (m_burst[u]) begin
                m_ptr[u] = (m_owner[u] + 1) % n;
                if (g < 0) begin
                    m_burst[u] = 1'b0;
                end else begin
                    m_beats[u]++;
                    if (m_beats[u] == BL) m_burst[u] = 1'b0;
                end
            end else if (g >= 0) begin
                m_owner[u] = g;
                m_ptr[u]   = (g + 1) % n;
                m_beats[u] = 1;
                m_burst[u] = BURST_MODE && (BL > 1);
            end
        end
    endtask

    task automatic cycle(input logic [3:0] r, input bit rst, input bit rdy);
        exp_t ea;
        exp_t eb;
        logic [15:0] d;
        @(negedge clk);
        d        = 16'($urandom);
        req      = r;
        req_data = d;
        reset    = rst;
        ready    = rdy;
        model_step(0, r, d, rst, rdy, ea);
        model_step(1, r, d, rst, rdy, eb);
        q_a.push_back(ea);
        q_b.push_back(eb);
    endtask

    task automatic run(input logic [3:0] r, input bit rst, input bit rdy, input int cycles);
        for (int i = 0; i < cycles; i++) cycle(r, rst, rdy);
    endtask

    // Monitor: settles after the driver's negedge update, then compares.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q_a.size() != 0) begin
                e = q_a.pop_front();
                check("gnt",   0, 32'(gnt_a),   32'(e.gnt));
                check("wr_en", 0, 32'(en_a),    32'(e.en));
                check("data",  0, 32'(data_a),  32'(e.data));
                check("owner", 0, 32'(owner_a), 32'(e.owner));
            end
            if (q_b.size() != 0) begin
                e = q_b.pop_front();
                check("gnt",   1, 32'(gnt_b),   32'(e.gnt[2:0]));
                check("wr_en", 1, 32'(en_b),    32'(e.en));
                check("data",  1, 32'(data_b),  32'(e.data));
                check("owner", 1, 32'(owner_b), 32'(e.owner));
            end
        end
    end

    initial begin
        reset    = 1'b1;
        req      = '0;
        req_data = '0;
        ready    = 1'b1;

        // Reset, then all requesting: 0,1,2,3,0 ... with data following.
        run(4'b1111, 1'b1, 1'b1, 2);
        run(4'b1111, 1'b0, 1'b1, 6);

        // Sparse requesters from ptr=0: only 1 and 3 are granted.
        run(4'b1010, 1'b1, 1'b1, 1);
        run(4'b1010, 1'b0, 1'b1, 5);

        // Backpressure mid-sequence, then resume in order.
        run(4'b1111, 1'b0, 1'b1, 2);
        run(4'b1111, 1'b0, 1'b0, 3);
        run(4'b1111, 1'b0, 1'b1, 3);

        // Single requester at the top index wraps ptr, then full order.
        run(4'b1111, 1'b1, 1'b1, 1);
        run(4'b0100, 1'b0, 1'b1, 2);
        run(4'b1111, 1'b0, 1'b1, 4);

        // Owner drops req part-way through a burst.
        run(4'b1111, 1'b1, 1'b1, 1);
        run(4'b1111, 1'b0, 1'b1, 2);
        run(4'b1110, 1'b0, 1'b1, 3);
        run(4'b1111, 1'b0, 1'b1, 2);

        // Reset asserted mid-burst, then fresh start from producer 0.
        run(4'b1111, 1'b1, 1'b1, 1);
        run(4'b1111, 1'b0, 1'b1, 3);
        run(4'b1111, 1'b1, 1'b1, 1);
        run(4'b1111, 1'b0, 1'b1, 3);

        // Randomised traffic with backpressure and occasional reset.
        for (int i = 0; i < 400; i++) begin
            cycle(4'($urandom), ($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 8));
        end

        @(negedge clk);
        #5;
        check("drain", 0, 32'(q_a.size()), 32'd0);
        check("drain", 1, 32'(q_b.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
